// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction prefetcher.
// It issues one memory read per cycle while prefetch credit remains.
// Responses are buffered in a DEPTH-entry circular queue for the CPU stage.
// A redirect flushes the queue and restarts fetch at the new address.
// Responses from requests issued before a redirect are discarded using an epoch tag.
// Optional feature: define FETCH_STALL_CNT_EN to add the stall_cycles starvation counter.
module instr_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    localparam int unsigned      PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W + 2)'(DEPTH);

    logic [31:0]    fetch_pc;
    logic           inflight;
    logic           inflight_epoch;
    logic [31:0]    inflight_pc;
    logic           epoch;
    logic [PTR_W:0] head;
    logic [PTR_W:0] tail;
    logic [31:0]    mem_instr [DEPTH];
    logic [31:0]    mem_pc    [DEPTH];

    logic           empty;
    logic           full;
    logic [PTR_W:0] count;
    logic [PTR_W+1:0] credit_used;
    logic           issue;
    logic           do_push;
    logic           do_pop;

    // Word alignment drops the low address bits of the redirect target.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // The low bits index the queue. The extra MSB is the wrap bit.
    assign empty = (head == tail);
    assign full  = (head[PTR_W-1:0] == tail[PTR_W-1:0]) && (head[PTR_W] != tail[PTR_W]);
    assign count = tail - head;
    assign credit_used = {1'b0, count} + (PTR_W + 2)'(inflight);

    // Decode the events of this cycle. A redirect suppresses issue, push and pop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        issue   = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!rst && !redirect_valid) begin
            issue   = (credit_used < DEPTH_W);
            do_push = inflight && (inflight_epoch == epoch);
            do_pop  = out_valid && out_ready;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = rst ? RESET_PC : fetch_pc;
    assign out_valid = !rst && !empty;
    assign out_instr = out_valid ? mem_instr[head[PTR_W-1:0]] : 32'h0;
    assign out_pc    = out_valid ? mem_pc[head[PTR_W-1:0]]    : 32'h0;

    // Control state: fetch address, in-flight tracking, epoch, queue pointers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register updates from the same pre-edge values.
        if (rst) begin
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_pc    <= 32'h0;
            epoch          <= 1'b0;
            head           <= '0;
            tail           <= '0;
        end else begin
            inflight       <= issue;
            inflight_epoch <= epoch;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                epoch    <= ~epoch;
                head     <= '0;
                tail     <= '0;
            end else begin
                if (issue) begin
                    fetch_pc    <= fetch_pc + 32'd4;
                    inflight_pc <= fetch_pc;
                end
                if (do_push) tail <= tail + 1'b1;
                if (do_pop)  head <= head + 1'b1;
            end
        end
    end

    // Queue storage: capture each accepted response, tagged with its request address.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset. The pointers define which entries are valid, and out_* are masked while the queue is empty.
        if (do_push) begin
            mem_instr[tail[PTR_W-1:0]] <= imem_rdata;
            mem_pc[tail[PTR_W-1:0]]    <= inflight_pc;
        end
    end

    // The credit rule must never allow a push into a full queue.
    push_not_full_a: assert property (@(posedge clk) disable iff (rst) !(do_push && full));

`ifdef FETCH_STALL_CNT_EN
    // Count cycles in which the CPU stage is ready but has nothing to take. The count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'h0;
        end else if (out_ready && !out_valid && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch (DEPTH=4, RESET_PC=0).
// The memory model returns instr_of(addr) one cycle after each request.
// If FETCH_STALL_CNT_EN is defined, the stall counter scenario also runs.
module tb_instr_fetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready = 1'b0;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // The instruction word differs from its address, so swapped fields show up.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    // Memory model: the word is valid in the cycle after the request.
    always @(posedge clk) imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    // Drive inputs for one cycle just after the edge, then settle before sampling.
    task automatic go(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst = r; out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
    endtask

    task automatic do_reset();
        go(1'b1, 1'b0, 1'b0, 32'h0);
        go(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", out_pc); end
`ifdef FETCH_STALL_CNT_EN
        checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cycles); end
`endif
        // Reset must override a simultaneous redirect.
        go(1'b1, 1'b0, 1'b1, 32'h0000_0500);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_redir_req got %b want 0", imem_req); end
    endtask

    // Reset release with out_ready high: requests 0,4,8... and delivery starts two cycles later.
    task automatic test_stream();
        logic [31:0] exp_pc;
        logic        exp_v;
        for (int i = 1; i <= 8; i++) begin
            go(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (i - 1))) begin
                errors++; $display("FAIL stream_req c%0d got %b/%h want 1/%h", i, imem_req, imem_addr, 32'(4 * (i - 1)));
            end
            exp_v = (i >= 3);
            checks++;
            if (out_valid !== exp_v) begin errors++; $display("FAIL stream_valid c%0d got %b want %b", i, out_valid, exp_v); end
            if (exp_v) begin
                exp_pc = 32'(4 * (i - 3));
                checks++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                    errors++; $display("FAIL stream_out c%0d got %h/%h want %h/%h", i, out_pc, out_instr, exp_pc, instr_of(exp_pc));
                end
            end
        end
    endtask

    // out_ready low: exactly DEPTH requests, then nothing. Draining then delivers in order and resumes at 0x10.
    task automatic test_backpressure();
        logic        exp_req;
        logic [31:0] drain_pc [6];
        drain_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            go(1'b0, 1'b0, 1'b0, 32'h0);
            exp_req = (i <= 4);
            checks++;
            if (imem_req !== exp_req) begin errors++; $display("FAIL bp_req c%0d got %b want %b", i, imem_req, exp_req); end
            if (exp_req) begin
                checks++;
                if (imem_addr !== 32'(4 * (i - 1))) begin errors++; $display("FAIL bp_addr c%0d got %h want %h", i, imem_addr, 32'(4 * (i - 1))); end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_head got %b/%h want 1/0", out_valid, out_pc); end
        for (int j = 1; j <= 6; j++) begin
            go(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (out_valid !== 1'b1 || out_pc !== drain_pc[j-1] || out_instr !== instr_of(drain_pc[j-1])) begin
                errors++; $display("FAIL bp_drain d%0d got %b/%h/%h want 1/%h", j, out_valid, out_pc, out_instr, drain_pc[j-1]);
            end
            if (j == 1) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req got %b want 0", imem_req); end
            end else begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'h10 + 32'(4 * (j - 2))) begin
                    errors++; $display("FAIL bp_resume d%0d got %b/%h want 1/%h", j, imem_req, imem_addr, 32'h10 + 32'(4 * (j - 2)));
                end
            end
        end
    endtask

    // Redirect while a response is arriving. The response and the old queue are dropped, and fetch restarts at 0x100.
    task automatic test_redirect();
        do_reset();
        repeat (3) go(1'b0, 1'b0, 1'b0, 32'h0);
        go(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req_n got %b want 0", imem_req); end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n1 got %b want 0", out_valid); end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_target got %b/%h want 1/100", imem_req, imem_addr); end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid_n2 got %b want 0", out_valid); end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== instr_of(32'h100)) begin
            errors++; $display("FAIL redir_first got %b/%h/%h want 1/100", out_valid, out_pc, out_instr);
        end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_pc !== 32'h104) begin errors++; $display("FAIL redir_second got %h want 104", out_pc); end
    endtask

    // Two redirects in consecutive cycles: the second one wins.
    task automatic test_back_to_back();
        go(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL b2b_req1 got %b want 0", imem_req); end
        go(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_req2 got %b/%b want 0/0", imem_req, out_valid); end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin errors++; $display("FAIL b2b_target got %b/%h want 1/300", imem_req, imem_addr); end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h300) begin errors++; $display("FAIL b2b_out got %b/%h want 1/300", out_valid, out_pc); end
    endtask

    // Fetch addresses wrap from 0xFFFF_FFFC to 0.
    task automatic test_wrap();
        logic [31:0] exp_req [5];
        logic [31:0] exp_out [5];
        exp_req = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        exp_out = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        go(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int k = 1; k <= 5; k++) begin
            go(1'b0, 1'b1, 1'b0, 32'h0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp_req[k-1]) begin
                errors++; $display("FAIL wrap_req k%0d got %b/%h want 1/%h", k, imem_req, imem_addr, exp_req[k-1]);
            end
            if (k >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_pc !== exp_out[k-1]) begin
                    errors++; $display("FAIL wrap_out k%0d got %b/%h want 1/%h", k, out_valid, out_pc, exp_out[k-1]);
                end
            end
        end
    endtask

    // Fill the queue, pulse reset for one cycle, and confirm no stale entry is delivered.
    task automatic test_reset_midstream();
        repeat (6) go(1'b0, 1'b0, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h4 || imem_req !== 1'b0) begin
            errors++; $display("FAIL mid_full got %b/%h/%b want 1/4/0", out_valid, out_pc, imem_req);
        end
        go(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_in_reset got %b/%b want 0/0", imem_req, out_valid); end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++; $display("FAIL mid_restart got %b/%b/%h want 0/1/%h", out_valid, imem_req, imem_addr, RESET_PC);
        end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %b want 0", out_valid); end
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC || out_instr !== instr_of(RESET_PC)) begin
            errors++; $display("FAIL mid_first got %b/%h/%h want 1/%h", out_valid, out_pc, out_instr, RESET_PC);
        end
    endtask

`ifdef FETCH_STALL_CNT_EN
    // Two starved cycles after reset release, and two more after a redirect.
    task automatic test_stall_counter();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            go(1'b0, 1'b1, 1'b0, 32'h0);
            if (i == 3) begin
                checks++;
                if (out_valid !== 1'b1 || stall_cycles !== 16'd2) begin
                    errors++; $display("FAIL stall_first got %b/%0d want 1/2", out_valid, stall_cycles);
                end
            end
        end
        go(1'b0, 1'b1, 1'b1, 32'h0000_0040);
        go(1'b0, 1'b1, 1'b0, 32'h0);
        go(1'b0, 1'b1, 1'b0, 32'h0);
        go(1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || stall_cycles !== 16'd4) begin
            errors++; $display("FAIL stall_redirect got %b/%0d want 1/4", out_valid, stall_cycles);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_midstream();
`ifdef FETCH_STALL_CNT_EN
        test_stall_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
